display_scan_mux: RTL

- Parametrised time-multiplexed driver for an N-digit segment display in the digital clock.
- Scans digits round-robin at a fixed slot rate and presents one digit's segment pattern at a time with a one-hot digit enable.
- Inserts a blanking interval at the start of each slot to prevent ghosting.
- Sits between the time/format logic (segment encoders) and the board display pins.

---
 rtl/display_scan_mux.sv | 125 ++++++++++++
 1 files changed

// File: rtl/display_scan_mux.sv
// display_scan_mux: round-robin scan driver for an N-digit segment display.
// Each digit owns a PRESCALE-cycle slot. The first BLANK_CYCLES cycles of a
// slot are dark to avoid ghosting. Segment data and the enable bit are
// captured once, at the start of the slot.
// Optional build macro DISPLAY_SCAN_DIM_EN adds a 4-bit brightness input,
// which PWM-gates the anode during the active part of each slot.
module display_scan_mux #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SEG_W        = 7,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 8,
  localparam int unsigned SEL_W       = $clog2(NUM_DIGITS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_DIGITS*SEG_W-1:0] data_flat,
  input  logic [NUM_DIGITS-1:0]       digit_en,
`ifdef DISPLAY_SCAN_DIM_EN
  input  logic [3:0]                  brightness,
`endif
  output logic [SEG_W-1:0]            seg_out,
  output logic [NUM_DIGITS-1:0]       anode,
  output logic [SEL_W-1:0]            sel,
  output logic                        frame_start
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // run_q distinguishes the reset state from a running scan, so that the
  // first edge after reset release is itself a slot-capture edge.
  logic                  run_q,   run_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [SEL_W-1:0]      sel_q,   sel_d;
  logic                  en_q,    en_d;
  logic [SEG_W-1:0]      seg_q,   seg_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  frame_q, frame_d;
  logic                  active_c;
  logic                  dim_ok_c;

  // Slot counter, digit index and per-slot capture of data/enable
  always_comb begin
    run_d = 1'b1;
    cnt_d = cnt_q;
    sel_d = sel_q;
    en_d  = en_q;
    seg_d = seg_q;
    if (!run_q) begin
      cnt_d = '0;
      sel_d = '0;
      seg_d = data_flat[sel_d*SEG_W +: SEG_W];
      en_d  = digit_en[sel_d];
    end else if (cnt_q == CNT_W'(PRESCALE - 1)) begin
      cnt_d = '0;
      sel_d = (sel_q == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel_q + SEL_W'(1);
      seg_d = data_flat[sel_d*SEG_W +: SEG_W];
      en_d  = digit_en[sel_d];
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Blanking window: anode may only light once the slot is past it
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign active_c = 1'b1;
    end else begin : g_blank
      assign active_c = (cnt_d >= CNT_W'(BLANK_CYCLES));
    end
  endgenerate

`ifdef DISPLAY_SCAN_DIM_EN
  logic [3:0] pwm_q, pwm_d;

  // Free-running PWM phase; anode lit while phase is below brightness
  always_comb begin
    pwm_d    = pwm_q + 4'd1;
    dim_ok_c = (brightness == 4'hF) || (pwm_d < brightness);
  end

  // PWM phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= 4'd0;
    else        pwm_q <= pwm_d;
  end
`else
  assign dim_ok_c = 1'b1;
`endif

  // Output decode for the cycle the new counter/index values describe
  always_comb begin
    anode_d = '0;
    if (en_d && active_c && dim_ok_c) begin
      anode_d = NUM_DIGITS'(1) << sel_d;
    end
    frame_d = run_d && (cnt_d == '0) && (sel_d == '0);
  end

  // State and output registers; reset darkens everything immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      seg_q   <= '0;
      anode_q <= '0;
      frame_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      seg_q   <= seg_d;
      anode_q <= anode_d;
      frame_q <= frame_d;
    end
  end

  assign seg_out     = seg_q;
  assign anode       = anode_q;
  assign sel         = sel_q;
  assign frame_start = frame_q;

endmodule
